// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, tag constants and source ids for the CDB arbiter
package cdb_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int ROB_ID_W = 4;
  localparam int ZERO_ROB = 0;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic {SRC_ALU = 1'b0, SRC_LSB = 1'b1} src_e;
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: per-source result buffer with wrapping head/tail pointers and flush
module cdb_src_fifo #(
  parameter int W = 36,
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    mem_d = mem_q;
    rd_d = rd_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d = '0;
      wr_d = '0;
      cnt_d = '0;
    end else begin
      if (push) mem_d[wr_q] = din;
      wr_d = push ? inc(wr_q) : wr_q;
      rd_d = pop ? inc(rd_q) : rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end
  assign head = mem_q[rd_q];
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin merge of ALU and LSB results onto one registered common data bus
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
  parameter int ROB_ID_W = cdb_arbiter_pkg::ROB_ID_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback_flag_from_rob,
  input  logic                valid_from_alu,
  input  logic [ROB_ID_W-1:0] rob_id_from_alu,
  input  logic [DATA_W-1:0]   result_from_alu,
  input  logic                valid_from_lsb,
  input  logic [ROB_ID_W-1:0] rob_id_from_lsb,
  input  logic [DATA_W-1:0]   result_from_lsb,
  output logic                full_to_alu,
  output logic                full_to_lsb,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_result
);
  localparam int EW = ROB_ID_W + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [EW-1:0] a_head, l_head, a_win, l_win;
  logic a_empty, l_empty, a_push, l_push, a_pop, l_pop;
  logic [CW-1:0] a_cnt, l_cnt;
  logic go, a_ok, l_ok, a_cand, l_cand, gnt_a, gnt_l;
  src_e last_grant_q, last_grant_d;
  logic cdb_valid_q, cdb_valid_d;
  logic [EW-1:0] cdb_q, cdb_d;
  assign full_to_alu = a_cnt == CW'(FIFO_DEPTH);
  assign full_to_lsb = l_cnt == CW'(FIFO_DEPTH);
  always_comb begin
    go = rdy && !rollback_flag_from_rob;
    a_ok = go && valid_from_alu && rob_id_from_alu != ROB_ID_W'(ZERO_ROB);
    l_ok = go && valid_from_lsb && rob_id_from_lsb != ROB_ID_W'(ZERO_ROB);
    a_cand = go && (!a_empty || a_ok);
    l_cand = go && (!l_empty || l_ok);
    gnt_l = l_cand && (!a_cand || last_grant_q == SRC_ALU);
    gnt_a = a_cand && !gnt_l;
    a_pop = gnt_a && !a_empty;
    l_pop = gnt_l && !l_empty;
    // a full buffer still takes a new entry when its own head leaves this cycle
    a_push = a_ok && (!full_to_alu || a_pop) && !(gnt_a && a_empty);
    l_push = l_ok && (!full_to_lsb || l_pop) && !(gnt_l && l_empty);
    a_win = a_empty ? {rob_id_from_alu, result_from_alu} : a_head;
    l_win = l_empty ? {rob_id_from_lsb, result_from_lsb} : l_head;
    last_grant_d = gnt_a ? SRC_ALU : gnt_l ? SRC_LSB : last_grant_q;
    cdb_valid_d = (gnt_a || gnt_l) ? TRUE : FALSE;
    cdb_d = gnt_a ? a_win : gnt_l ? l_win : cdb_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SRC_LSB;
      cdb_valid_q <= FALSE;
      cdb_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_q <= cdb_d;
    end
  end
  assign cdb_valid = cdb_valid_q;
  assign {cdb_rob_id, cdb_result} = cdb_q;
  cdb_src_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk(clk), .rst(rst), .flush(rollback_flag_from_rob), .push(a_push), .pop(a_pop),
    .din({rob_id_from_alu, result_from_alu}), .head(a_head), .empty(a_empty), .count(a_cnt)
  );
  cdb_src_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk(clk), .rst(rst), .flush(rollback_flag_from_rob), .push(l_push), .pop(l_pop),
    .din({rob_id_from_lsb, result_from_lsb}), .head(l_head), .empty(l_empty), .count(l_cnt)
  );
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed stimulus with a broadcast scoreboard for cdb_arbiter
module tb_cdb_arbiter;
  logic clk = 1'b0, rst, rdy, rb;
  logic va, vl;
  logic [3:0] ia, il, cdb_rob_id;
  logic [31:0] rsa, rsl, cdb_result;
  logic full_to_alu, full_to_lsb, cdb_valid;
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_flag_from_rob(rb),
    .valid_from_alu(va), .rob_id_from_alu(ia), .result_from_alu(rsa),
    .valid_from_lsb(vl), .rob_id_from_lsb(il), .result_from_lsb(rsl),
    .full_to_alu(full_to_alu), .full_to_lsb(full_to_lsb),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result)
  );
  function automatic logic [31:0] ra(input logic [3:0] id);
    return 32'hA000_0000 | 32'(id);
  endfunction
  function automatic logic [31:0] rl(input logic [3:0] id);
    return 32'hB000_0000 | 32'(id);
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic ex(input logic [3:0] id, input logic [31:0] r);
    exp_q.push_back({id, r});
  endtask
  task automatic cyc(input logic a, input logic [3:0] aid, input logic [31:0] ar,
                     input logic l, input logic [3:0] lid, input logic [31:0] lr);
    va = a; ia = aid; rsa = ar; vl = l; il = lid; rsl = lr;
    @(posedge clk);
    #1;
    va = 1'b0; vl = 1'b0;
  endtask
  task automatic both(input logic [3:0] a, input logic [3:0] l);
    cyc(1, a, ra(a), 1, l, rl(l));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clk) begin
    if (cdb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bcast: got id=%0d res=%h expected none", cdb_rob_id, cdb_result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("bcast", 64'({cdb_rob_id, cdb_result}), 64'(mon_e));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1; rdy = 1; rb = 0; va = 0; vl = 0; ia = 0; il = 0; rsa = 0; rsl = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_valid", 64'(cdb_valid), 0);
    chk("rst_id", 64'(cdb_rob_id), 0);
    chk("rst_res", 64'(cdb_result), 0);
    chk("rst_full", 64'({full_to_alu, full_to_lsb}), 0);
    // single ALU result, one-cycle latency, single-cycle pulse
    ex(3, 32'h1234);
    cyc(1, 3, 32'h1234, 0, 0, 0);
    chk("alone_valid", 64'(cdb_valid), 1);
    chk("alone_id", 64'(cdb_rob_id), 3);
    idle(1);
    chk("alone_pulse", 64'(cdb_valid), 0);
    chk("alone_hold", 64'(cdb_result), 64'h1234);
    // tie right after reset: ALU first
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    ex(1, ra(1)); ex(2, rl(2));
    both(1, 2);
    chk("tie_first", 64'(cdb_rob_id), 1);
    idle(1);
    chk("tie_second", 64'({cdb_valid, cdb_rob_id}), 64'({1'b1, 4'd2}));
    idle(1);
    chk("tie_done", 64'(cdb_valid), 0);
    // sustained contention: L13 and A6 arrive while full and losing, so they drop
    ex(1, ra(1)); ex(9, rl(9)); ex(2, ra(2)); ex(10, rl(10)); ex(3, ra(3));
    ex(11, rl(11)); ex(4, ra(4)); ex(12, rl(12)); ex(5, ra(5)); ex(14, rl(14));
    for (int i = 0; i < 6; i++) begin
      both(4'(1 + i), 4'(9 + i));
      if (i == 2) chk("cont_full_c3", 64'({full_to_alu, full_to_lsb}), 64'(2'b01));
      if (i == 3) chk("cont_full_c4", 64'({full_to_alu, full_to_lsb}), 64'(2'b11));
    end
    idle(6);
    chk("cont_drained", 64'(exp_q.size()), 0);
    // rollback with two entries buffered per source
    ex(1, ra(1)); ex(2, rl(2)); ex(3, ra(3)); ex(4, rl(4));
    both(1, 2); both(3, 4); both(6, 7); both(8, 9);
    chk("rb_pre_full", 64'({full_to_alu, full_to_lsb}), 64'(2'b11));
    rb = 1;
    both(10, 11);
    rb = 0;
    chk("rb_valid", 64'(cdb_valid), 0);
    chk("rb_full", 64'({full_to_alu, full_to_lsb}), 0);
    ex(5, ra(5));
    cyc(1, 5, ra(5), 0, 0, 0);
    chk("rb_fresh", 64'({cdb_valid, cdb_rob_id}), 64'({1'b1, 4'd5}));
    idle(3);
    // rdy low with LSB id 7 buffered
    ex(3, rl(3));
    cyc(0, 0, 0, 1, 3, rl(3));
    ex(1, ra(1)); ex(7, rl(7));
    both(1, 7);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 9, ra(9), 0, 0, 0);
      chk("rdy_low_valid", 64'(cdb_valid), 0);
    end
    rdy = 1;
    idle(1);
    chk("rdy_resume", 64'({cdb_valid, cdb_rob_id}), 64'({1'b1, 4'd7}));
    idle(2);
    // reset with full buffers, then a zero tag that must never appear
    ex(1, ra(1)); ex(2, rl(2)); ex(3, ra(3)); ex(4, rl(4));
    both(1, 2); both(3, 4); both(6, 7); both(8, 9);
    chk("rst2_pre_full", 64'({full_to_alu, full_to_lsb}), 64'(2'b11));
    rst = 1;
    both(10, 11);
    rst = 0;
    chk("rst2_valid", 64'(cdb_valid), 0);
    chk("rst2_data", 64'({cdb_rob_id, cdb_result}), 0);
    chk("rst2_full", 64'({full_to_alu, full_to_lsb}), 0);
    idle(1);
    chk("rst2_no_bcast", 64'(cdb_valid), 0);
    cyc(1, 0, 32'hDEAD_BEEF, 1, 0, 32'hBAD0_0000);
    chk("zero_tag", 64'(cdb_valid), 0);
    idle(4);
    chk("final_drain", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
